// File: rtl/dma_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : dma_reg_bank
// Purpose  : DMA configuration register bank and ring-pointer tracker. Takes
//            the word-indexed register port from the AXI-Lite front end,
//            holds the configuration and ring pointers, advances the ring
//            head on engine completion pulses, counts completed buffers and
//            raises the DMA interrupt.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            reg_addr/wdata/write  - register write port (index = byte addr[11:3])
//            reg_rdata             - combinational read data for reg_addr
//            src_base, dest_base   - 32-bit base addresses to the engine
//            head_ptr, tail_ptr    - ring pointers (RING_PTR_W bits)
//            dma_size              - bytes consumed per buffer
//            dma_en, dma_pending   - enable, registered "work available" flag
//            head_inc, done_evt    - engine pulses (buffer consumed / done)
//            dma_intr              - interrupt (INTR & IE)
// Revision : 1.0 - initial release
// ============================================================================
module dma_reg_bank #(
  parameter int RING_PTR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8:0]            reg_addr,
  input  logic [31:0]           reg_wdata,
  input  logic                  reg_write,
  output logic [31:0]           reg_rdata,
  output logic [31:0]           src_base,
  output logic [31:0]           dest_base,
  output logic [RING_PTR_W-1:0] head_ptr,
  output logic [RING_PTR_W-1:0] tail_ptr,
  output logic [RING_PTR_W-1:0] dma_size,
  output logic                  dma_en,
  output logic                  dma_pending,
  input  logic                  head_inc,
  input  logic                  done_evt,
  output logic                  dma_intr
);

  localparam logic [8:0] C_IDX_SRC  = 9'd0;
  localparam logic [8:0] C_IDX_DEST = 9'd1;
  localparam logic [8:0] C_IDX_TAIL = 9'd2;
  localparam logic [8:0] C_IDX_HEAD = 9'd3;
  localparam logic [8:0] C_IDX_SIZE = 9'd4;
  localparam logic [8:0] C_IDX_CTRL = 9'd5;
  localparam logic [8:0] C_IDX_DONE = 9'd6;
  localparam logic [8:0] C_IDX_RLEN = 9'd7;

  logic [31:0]           r_src;
  logic [31:0]           r_dest;
  logic [RING_PTR_W-1:0] r_tail;
  logic [RING_PTR_W-1:0] r_head;
  logic [RING_PTR_W-1:0] r_size;
  logic [RING_PTR_W-1:0] r_ring_len;
  logic                  r_en;
  logic                  r_ie;
  logic                  r_intr;
  logic [31:0]           r_done_cnt;
  logic                  r_pending;

  logic                  w_wr_src;
  logic                  w_wr_dest;
  logic                  w_wr_tail;
  logic                  w_wr_head;
  logic                  w_wr_size;
  logic                  w_wr_ctrl;
  logic                  w_wr_rlen;
  logic [RING_PTR_W:0]   w_sum;
  logic [RING_PTR_W-1:0] w_wrap;
  logic [RING_PTR_W-1:0] w_head_adv;

  assign w_wr_src  = reg_write && (reg_addr == C_IDX_SRC);
  assign w_wr_dest = reg_write && (reg_addr == C_IDX_DEST);
  assign w_wr_tail = reg_write && (reg_addr == C_IDX_TAIL);
  assign w_wr_head = reg_write && (reg_addr == C_IDX_HEAD);
  assign w_wr_size = reg_write && (reg_addr == C_IDX_SIZE);
  assign w_wr_ctrl = reg_write && (reg_addr == C_IDX_CTRL);
  assign w_wr_rlen = reg_write && (reg_addr == C_IDX_RLEN);

  // Head advance uses the current (pre-write) size and ring length, so a
  // same-cycle CPU write to either only affects later advances. The sum keeps
  // a carry bit so the wrap compare is exact; the wrapped result always fits
  // in RING_PTR_W bits because size never exceeds the ring length.
  always_comb begin
    w_sum      = {1'b0, r_head} + {1'b0, r_size};
    w_wrap     = w_sum[RING_PTR_W-1:0] - r_ring_len;
    w_head_adv = w_sum[RING_PTR_W-1:0];
    if ((r_ring_len != '0) && (w_sum >= {1'b0, r_ring_len})) begin
      w_head_adv = w_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src      <= '0;
      r_dest     <= '0;
      r_tail     <= '0;
      r_head     <= '0;
      r_size     <= '0;
      r_ring_len <= '0;
      r_en       <= 1'b0;
      r_ie       <= 1'b0;
      r_intr     <= 1'b0;
      r_done_cnt <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (w_wr_src)  r_src      <= reg_wdata;
      if (w_wr_dest) r_dest     <= reg_wdata;
      if (w_wr_tail) r_tail     <= reg_wdata[RING_PTR_W-1:0];
      if (w_wr_size) r_size     <= reg_wdata[RING_PTR_W-1:0];
      if (w_wr_rlen) r_ring_len <= reg_wdata[RING_PTR_W-1:0];

      // CPU write beats the engine advance; the advance needs EN.
      if (w_wr_head) begin
        r_head <= reg_wdata[RING_PTR_W-1:0];
      end else if (head_inc && r_en) begin
        r_head <= w_head_adv;
      end

      if (w_wr_ctrl) begin
        r_en <= reg_wdata[0];
        r_ie <= reg_wdata[1];
      end

      // Set dominates the write-1-to-clear.
      if (done_evt) begin
        r_intr <= 1'b1;
      end else if (w_wr_ctrl && reg_wdata[31]) begin
        r_intr <= 1'b0;
      end

      // Counts every consumed buffer, regardless of EN or a head overwrite.
      if (head_inc) r_done_cnt <= r_done_cnt + 32'd1;

      // Sampled from the register values as they stand this cycle, giving a
      // one-cycle lag behind the pointer/enable registers.
      r_pending <= r_en && (r_head != r_tail);
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      C_IDX_SRC:  reg_rdata = r_src;
      C_IDX_DEST: reg_rdata = r_dest;
      C_IDX_TAIL: reg_rdata = 32'(r_tail);
      C_IDX_HEAD: reg_rdata = 32'(r_head);
      C_IDX_SIZE: reg_rdata = 32'(r_size);
      C_IDX_CTRL: reg_rdata = {r_intr, 29'd0, r_ie, r_en};
      C_IDX_DONE: reg_rdata = r_done_cnt;
      C_IDX_RLEN: reg_rdata = 32'(r_ring_len);
      default:    reg_rdata = '0;
    endcase
  end

  assign src_base    = r_src;
  assign dest_base   = r_dest;
  assign head_ptr    = r_head;
  assign tail_ptr    = r_tail;
  assign dma_size    = r_size;
  assign dma_en      = r_en;
  assign dma_pending = r_pending;
  assign dma_intr    = r_intr & r_ie;

endmodule
`default_nettype wire

// File: tb/tb_dma_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_reg_bank
// Purpose  : Directed self-checking bench for dma_reg_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [8:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_write;
  logic [31:0] reg_rdata;
  logic [31:0] src_base;
  logic [31:0] dest_base;
  logic [31:0] head_ptr;
  logic [31:0] tail_ptr;
  logic [31:0] dma_size;
  logic        dma_en;
  logic        dma_pending;
  logic        head_inc;
  logic        done_evt;
  logic        dma_intr;

  int checks = 0;
  int errors = 0;

  dma_reg_bank #(.RING_PTR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_write   (reg_write),
    .reg_rdata   (reg_rdata),
    .src_base    (src_base),
    .dest_base   (dest_base),
    .head_ptr    (head_ptr),
    .tail_ptr    (tail_ptr),
    .dma_size    (dma_size),
    .dma_en      (dma_en),
    .dma_pending (dma_pending),
    .head_inc    (head_inc),
    .done_evt    (done_evt),
    .dma_intr    (dma_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One-cycle stimulus: drive at a falling edge, hold across one rising edge,
  // return at the next falling edge with everything deasserted.
  task automatic step(input logic we, input logic [8:0] a, input logic [31:0] d,
                      input logic hi, input logic de);
    @(negedge clk);
    reg_write = we;
    reg_addr  = a;
    reg_wdata = d;
    head_inc  = hi;
    done_evt  = de;
    @(negedge clk);
    reg_write = 1'b0;
    head_inc  = 1'b0;
    done_evt  = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [8:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    chk(tag, reg_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    reg_write = 1'b0;
    head_inc  = 1'b0;
    done_evt  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    for (int i = 0; i <= 8; i++) rd($sformatf("reset_rd%0d", i), 9'(i), 32'h0);
    chk("reset_outs", {src_base[0], head_ptr[0], dma_en, dma_pending, dma_intr}, 32'h0);

    wr(9'd0, 32'h0000_1000);
    rd("src_rd", 9'd0, 32'h0000_1000);
    chk("src_base", src_base, 32'h0000_1000);

    // Ring wrap: 0xC0 + 0x40 = 0x100 >= 0x100 -> 0x00; then 0x40
    wr(9'd7, 32'h100);
    wr(9'd4, 32'h40);
    wr(9'd3, 32'hC0);
    wr(9'd5, 32'h1);
    step(1'b0, 9'd0, 32'h0, 1'b1, 1'b0);
    chk("wrap_head", head_ptr, 32'h00);
    rd("cnt1", 9'd6, 32'd1);
    step(1'b0, 9'd0, 32'h0, 1'b1, 1'b0);
    chk("head_40", head_ptr, 32'h40);
    rd("cnt2", 9'd6, 32'd2);

    // Pending timing
    wr(9'd5, 32'h0);
    wr(9'd2, 32'h80);
    wr(9'd3, 32'h0);
    wr(9'd5, 32'h1);
    chk("pend_lag", 32'(dma_pending), 32'h0);
    @(negedge clk);
    chk("pend_set", 32'(dma_pending), 32'h1);
    step(1'b0, 9'd0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 9'd0, 32'h0, 1'b1, 1'b0);
    chk("head_80", head_ptr, 32'h80);
    chk("pend_hold", 32'(dma_pending), 32'h1);
    @(negedge clk);
    chk("pend_clr", 32'(dma_pending), 32'h0);

    // Interrupt
    wr(9'd5, 32'h3);
    chk("intr_idle", 32'(dma_intr), 32'h0);
    step(1'b0, 9'd0, 32'h0, 1'b0, 1'b1);
    chk("intr_set", 32'(dma_intr), 32'h1);
    step(1'b1, 9'd5, 32'h8000_0003, 1'b0, 1'b1);
    chk("intr_setwins", 32'(dma_intr), 32'h1);
    rd("ctrl_setwins", 9'd5, 32'h8000_0003);
    wr(9'd5, 32'h8000_0003);
    rd("ctrl_w1c", 9'd5, 32'h0000_0003);
    chk("intr_clr", 32'(dma_intr), 32'h0);

    // Head write vs head_inc, EN=0 suppression
    step(1'b1, 9'd3, 32'h20, 1'b1, 1'b0);
    chk("head_cpuwins", head_ptr, 32'h20);
    rd("cnt5", 9'd6, 32'd5);
    wr(9'd5, 32'h0);
    step(1'b0, 9'd0, 32'h0, 1'b1, 1'b0);
    chk("head_en0", head_ptr, 32'h20);
    rd("cnt6", 9'd6, 32'd6);

    // Size write with head_inc uses old size; back-to-back pulses
    wr(9'd5, 32'h1);
    step(1'b1, 9'd4, 32'h10, 1'b1, 1'b0);
    chk("head_oldsize", head_ptr, 32'h60);
    @(negedge clk);
    head_inc = 1'b1;
    @(negedge clk);
    chk("b2b_first", head_ptr, 32'h70);
    @(negedge clk);
    head_inc = 1'b0;
    chk("b2b_second", head_ptr, 32'h80);
    rd("cnt9", 9'd6, 32'd9);

    // Ignored writes
    wr(9'd9, 32'hFFFF_FFFF);
    rd("idx9", 9'd9, 32'h0);
    wr(9'd6, 32'd5);
    rd("cnt_ro", 9'd6, 32'd9);

    // RING_LEN=0 truncates
    wr(9'd7, 32'h0);
    wr(9'd3, 32'hFFFF_FFF0);
    step(1'b0, 9'd0, 32'h0, 1'b1, 1'b0);
    chk("head_trunc", head_ptr, 32'h0);
    rd("cnt10", 9'd6, 32'd10);

    // Asynchronous reset mid-burst (pending is 1 here: head 0, tail 0x80)
    @(negedge clk);
    chk("pre_rst_pend", 32'(dma_pending), 32'h1);
    head_inc = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_head", head_ptr, 32'h0);
    chk("rst_src", src_base, 32'h0);
    chk("rst_misc", {dma_en, dma_pending, dma_intr}, 32'h0);
    rd("rst_cnt", 9'd6, 32'h0);
    head_inc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd("post_rst_cnt", 9'd6, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
